arf_engine: RTL and testbench

Time-multiplexed auto-regressive filter (ARF) engine. It evaluates the 28-node ARF data-flow graph (16 multiplies, 12 adds) on a single shared multiplier and a single shared adder, one node per cycle. Unlike the fully parallel ARF netlist, it has a run-time programmable coefficient bank, two feedback state registers and valid/ready handshakes. It sits between the sample source and the result sink in the DFG scheduling test environment.

---
 rtl/arf_engine.sv | 136 +++++++++++++
 tb/tb_arf_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/arf_engine.sv
// Time-multiplexed 28-node auto-regressive filter: one shared multiplier and one
// shared adder evaluate one graph node per cycle, with programmable coefficients and feedback.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, coefficient writes honoured, waits for a sample
// RUN   | step 0..27 evaluates node step+1; step 28 latches y0/y1
// DONE  | out_valid high, result held until out_ready
module arf_engine #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_y0,
    output logic [W-1:0]   out_y1,
    input  logic           cfg_we,
    input  logic [3:0]     cfg_addr,
    input  logic [W-1:0]   cfg_data,
    input  logic           clear_state,
    output logic           busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state;
    logic [4:0]   step;
    logic [W-1:0] x    [8];
    logic [W-1:0] coef [16];
    logic [W-1:0] scr  [28];
    logic [W-1:0] z0, z1;

    logic         is_mul;
    logic [W-1:0] op_a, op_b, result;

    // scr[n] holds node n+1 (m1 in scr[0], a28 in scr[27])
    always_comb begin
        is_mul = 1'b0;
        op_a   = '0;
        op_b   = '0;
        if (step < 5'd8) begin
            is_mul = 1'b1;
            op_a   = x[step[2:0]];
            op_b   = coef[{1'b0, step[2:0]}];
        end else begin
            case (step)
                5'd8:  begin op_a = scr[0];  op_b = scr[1];  end
                5'd9:  begin op_a = scr[2];  op_b = scr[3];  end
                5'd10: begin op_a = scr[4];  op_b = scr[5];  end
                5'd11: begin op_a = scr[6];  op_b = scr[7];  end
                5'd12: begin op_a = scr[9];  op_b = z0;      end
                5'd13: begin op_a = scr[10]; op_b = z1;      end
                5'd14: begin is_mul = 1'b1; op_a = scr[12]; op_b = coef[8];  end
                5'd15: begin is_mul = 1'b1; op_a = scr[13]; op_b = coef[9];  end
                5'd16: begin is_mul = 1'b1; op_a = scr[12]; op_b = coef[10]; end
                5'd17: begin is_mul = 1'b1; op_a = scr[13]; op_b = coef[11]; end
                5'd18: begin op_a = scr[14]; op_b = scr[15]; end
                5'd19: begin op_a = scr[16]; op_b = scr[17]; end
                5'd20: begin is_mul = 1'b1; op_a = scr[18]; op_b = coef[12]; end
                5'd21: begin is_mul = 1'b1; op_a = scr[19]; op_b = coef[13]; end
                5'd22: begin is_mul = 1'b1; op_a = scr[18]; op_b = coef[14]; end
                5'd23: begin is_mul = 1'b1; op_a = scr[19]; op_b = coef[15]; end
                5'd24: begin op_a = scr[20]; op_b = scr[21]; end
                5'd25: begin op_a = scr[22]; op_b = scr[23]; end
                5'd26: begin op_a = scr[8];  op_b = scr[24]; end
                5'd27: begin op_a = scr[11]; op_b = scr[25]; end
                default: begin op_a = '0; op_b = '0; end
            endcase
        end
        // low W bits of a two's-complement product do not depend on signedness
        result = is_mul ? (op_a * op_b) : (op_a + op_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            step   <= '0;
            out_y0 <= '0;
            out_y1 <= '0;
            for (int i = 0; i < 8; i++) x[i] <= '0;
            for (int i = 0; i < 28; i++) scr[i] <= '0;
            for (int i = 0; i < 16; i++)
                coef[i] <= (i >= 12 && i <= 14) ? -W'(3) : W'(3);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_we) coef[cfg_addr] <= cfg_data;
                    if (in_valid) begin
                        for (int i = 0; i < 8; i++) x[i] <= in_data[i*W +: W];
                        step  <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (step == 5'd28) begin
                        out_y0 <= scr[26];
                        out_y1 <= scr[27];
                        state  <= ST_DONE;
                    end else begin
                        scr[step] <= result;
                        step      <= step + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // z0 takes a27 (already stored) while z1 takes a28 straight off the adder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z0 <= '0;
            z1 <= '0;
        end else if (clear_state) begin
            z0 <= '0;
            z1 <= '0;
        end else if (state == ST_RUN && step == 5'd27) begin
            z0 <= scr[26];
            z1 <= result;
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);

endmodule

// File: tb/tb_arf_engine.sv
// Self-checking bench for arf_engine: directed scenarios plus randomized samples
// checked against a closed-form arithmetic model of the filter graph.
module tb_arf_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [15:0]  out_y0, out_y1;
    logic         cfg_we = 1'b0;
    logic [3:0]   cfg_addr = '0;
    logic [15:0]  cfg_data = '0;
    logic         clear_state = 1'b0;
    logic         busy;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] m_coef [16];
    logic [15:0] m_z0, m_z1;

    localparam logic [127:0] ONES = {8{16'h0001}};

    arf_engine #(.W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y0(out_y0), .out_y1(out_y1),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .clear_state(clear_state), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++)
            m_coef[i] = (i >= 12 && i <= 14) ? 16'hFFFD : 16'h0003;
        m_z0 = '0;
        m_z1 = '0;
    endtask

    // Whole graph collapsed into sums of products; wrapping only at the end
    // is equivalent since every operation is modulo 2^16.
    function automatic void model(input logic [127:0] xv, output logic [15:0] y0, output logic [15:0] y1);
        int c[16];
        int m[8];
        int a13, a14, a19, a20;
        for (int i = 0; i < 16; i++) c[i] = int'($signed(m_coef[i]));
        for (int i = 0; i < 8; i++) m[i] = int'($signed(xv[i*16 +: 16])) * c[i];
        a13 = m[2] + m[3] + int'($signed(m_z0));
        a14 = m[4] + m[5] + int'($signed(m_z1));
        a19 = a13 * c[8] + a14 * c[9];
        a20 = a13 * c[10] + a14 * c[11];
        y0 = 16'(m[0] + m[1] + a19 * c[12] + a20 * c[13]);
        y1 = 16'(m[6] + m[7] + a19 * c[14] + a20 * c[15]);
    endfunction

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_coef[a] = d;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_state = 1'b1;
        @(posedge clk); #1;
        clear_state = 1'b0;
        m_z0 = '0;
        m_z1 = '0;
    endtask

    task automatic do_sample(input logic [127:0] xv, input logic [15:0] e0, input logic [15:0] e1,
                             input bit acc_we, input logic [3:0] acc_addr, input logic [15:0] acc_data,
                             input bit run_cfg, input bit bp, input bit clr27, input string tag);
        int n;
        @(negedge clk);
        in_data = xv; in_valid = 1'b1;
        cfg_we = acc_we; cfg_addr = acc_addr; cfg_data = acc_data;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        if (run_cfg) begin
            cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'h0007;
        end
        for (n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                check({tag, "_in_ready_run"}, in_ready, 0);
                check({tag, "_busy_run"}, busy, 1);
            end
            if (n == 5) cfg_we = 1'b0;
            if (clr27 && n == 27) clear_state = 1'b1;
            if (clr27 && n == 28) clear_state = 1'b0;
            if (out_valid) break;
        end
        check({tag, "_latency"}, n, 29);
        check({tag, "_y0"}, out_y0, e0);
        check({tag, "_y1"}, out_y1, e1);
        if (bp) begin
            in_valid = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                check({tag, "_bp_valid"}, out_valid, 1);
                check({tag, "_bp_in_ready"}, in_ready, 0);
                check({tag, "_bp_y0"}, out_y0, e0);
                check({tag, "_bp_y1"}, out_y1, e1);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_idle_in_ready"}, in_ready, 1);
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        logic [15:0] e0, e1;
        logic [127:0] xv;
        bit seen;
        bit acc;
        logic [3:0] aa;
        logic [15:0] ad;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_y0", out_y0, 0);
        check("rst_y1", out_y1, 0);

        // reset defaults, zero feedback
        do_sample(ONES, 16'hFF2E, 16'h0006, 0, 0, 0, 0, 0, 0, "ones1");
        m_z0 = 16'hFF2E; m_z1 = 16'h0006;

        // feedback from the previous result
        do_sample(ONES, 16'h0D86, 16'h0006, 0, 0, 0, 0, 0, 0, "ones2");
        m_z0 = 16'h0D86; m_z1 = 16'h0006;

        // wrapped product and wrapped sum
        do_clear();
        do_sample({96'h0, 16'h7FFF, 16'h7FFF}, 16'hFFFA, 16'h0000, 0, 0, 0, 0, 0, 0, "ovf");
        m_z0 = 16'hFFFA; m_z1 = 16'h0000;

        // coefficient write in IDLE, then a write during RUN that must be dropped
        cfg_write(4'd0, 16'h0001);
        do_clear();
        do_sample(ONES, 16'hFF2C, 16'h0006, 0, 0, 0, 0, 0, 0, "cfg1");
        do_clear();
        do_sample(ONES, 16'hFF2C, 16'h0006, 0, 0, 0, 1, 0, 0, "cfg_run");
        do_clear();
        do_sample(ONES, 16'hFF2C, 16'h0006, 0, 0, 0, 0, 0, 0, "cfg_drop");

        // backpressure in DONE
        do_clear();
        out_ready = 1'b0;
        do_sample(ONES, 16'hFF2C, 16'h0006, 0, 0, 0, 0, 1, 0, "bp");
        m_z0 = 16'hFF2C; m_z1 = 16'h0006;
        check("bp_no_accept", busy, 0);

        // clear_state on the step-27 edge beats the feedback update
        model(ONES, e0, e1);
        do_sample(ONES, e0, e1, 0, 0, 0, 0, 0, 1, "clr27");
        m_z0 = '0; m_z1 = '0;
        do_sample(ONES, 16'hFF2C, 16'h0006, 0, 0, 0, 0, 0, 0, "after_clr27");

        // reset during step 12 aborts the sample and restores every default
        @(negedge clk);
        in_data = ONES; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_y0", out_y0, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        check("abort_in_ready", in_ready, 1);
        do_sample(ONES, 16'hFF2E, 16'h0006, 0, 0, 0, 0, 0, 0, "post_abort");
        m_z0 = 16'hFF2E; m_z1 = 16'h0006;

        // randomized samples, coefficient writes and clears
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 2) == 0) do_clear();
            repeat ($urandom_range(0, 2)) cfg_write(4'($urandom), 16'($urandom));
            acc = 1'($urandom_range(0, 1));
            aa  = 4'($urandom);
            ad  = 16'($urandom);
            if (acc) m_coef[aa] = ad;
            xv = {$urandom, $urandom, $urandom, $urandom};
            model(xv, e0, e1);
            do_sample(xv, e0, e1, acc, aa, ad, 0, 0, 0, $sformatf("rand%0d", it));
            m_z0 = e0; m_z1 = e1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
